// File: rtl/cpu_parameters.sv
// Core-wide constants shared by the execute and write-back stages.
package cpu_parameters;
  localparam int XLEN         = 32;
  localparam int NUM_SRC      = 3;
  localparam int STARVE_LIMIT = 4;

  localparam int SRC_MEM = 0;
  localparam int SRC_ALU = 1;
  localparam int SRC_CSR = 2;

  typedef enum logic {
    ARB_RUN  = 1'b0,
    ARB_HALT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/interfaces_pkg.sv
// Bus structures passed between pipeline stages.
package interfaces_pkg;
  import cpu_parameters::*;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      adr;
  } wb_bus;
endpackage

// File: rtl/wb_age_counter.sv
// Saturating wait counter for one write-back requester; flags starvation.
module wb_age_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         freeze,
  output logic         starved,
  output logic [W-1:0] age
);
  // freeze outranks clr so a halted arbiter keeps its fairness history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (freeze) begin
      age <= age;
    end else if (clr) begin
      age <= '0;
    end else if (inc && (age < W'(LIMIT))) begin
      age <= age + W'(1);
    end
  end

  assign starved = (age >= W'(LIMIT));
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: fixed priority MEM > ALU > CSR with an
// age override, registered write-back, and exception halt until flush.
module wb_arbiter
  import cpu_parameters::*;
  import interfaces_pkg::*;
#(
  parameter int N_SRC  = NUM_SRC,
  parameter int LIMIT  = STARVE_LIMIT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  input  logic [N_SRC-1:0][XLEN-1:0] src_data,
  input  logic [N_SRC-1:0][4:0]      src_rd,
  input  logic [N_SRC-1:0]           src_exc,
  input  logic                       flush,
  output wb_bus                      wb,
  output logic                       wb_valid,
  output logic                       exc_valid,
  output logic [1:0]                 exc_src,
  output logic                       halted,
  output arb_state_t                 state_dbg
);
  localparam int AGE_W = $clog2(LIMIT + 1);

  arb_state_t           state, state_next;
  logic [N_SRC-1:0]     starved;
  logic [N_SRC-1:0]     age_inc, age_clr;
  logic [AGE_W-1:0]     age [N_SRC];
  logic                 age_freeze;
  logic                 grant_any, starved_hit, plain_hit;
  logic [1:0]           grant_idx;
  logic [N_SRC-1:0]     grant;
  logic [XLEN-1:0]      sel_data;
  logic [4:0]           sel_rd;
  logic                 sel_exc;

  // Valid/ready: a source transfers on a clock edge where src_valid[i] and
  // src_ready[i] are both high; ready never depends on data, rd or exc.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_any   = 1'b0;
    starved_hit = 1'b0;
    plain_hit   = 1'b0;
    if (rst_n && (state == ARB_RUN) && !flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!starved_hit && src_valid[i] && starved[i]) begin
          starved_hit = 1'b1;
          grant_idx   = 2'(i);
        end
      end
      if (!starved_hit) begin
        for (int i = 0; i < N_SRC; i++) begin
          if (!plain_hit && src_valid[i]) begin
            plain_hit = 1'b1;
            grant_idx = 2'(i);
          end
        end
      end
      grant_any = starved_hit | plain_hit;
      for (int i = 0; i < N_SRC; i++) begin
        grant[i] = grant_any && (grant_idx == 2'(i));
      end
    end
  end

  assign src_ready = grant;

  always_comb begin
    sel_data = '0;
    sel_rd   = '0;
    sel_exc  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        sel_data = src_data[i];
        sel_rd   = src_rd[i];
        sel_exc  = src_exc[i];
      end
    end
  end

  assign age_freeze = (state == ARB_HALT) && !flush;
  assign age_inc    = src_valid & ~grant;
  assign age_clr    = {N_SRC{flush}} | ~src_valid | grant;

  for (genvar g = 0; g < N_SRC; g++) begin : g_age
    wb_age_counter #(.LIMIT(LIMIT), .W(AGE_W)) u_age (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (age_inc[g]),
      .clr     (age_clr[g]),
      .freeze  (age_freeze),
      .starved (starved[g]),
      .age     (age[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ARB_RUN;
    end else if ((state == ARB_RUN) && grant_any && sel_exc) begin
      state_next = ARB_HALT;
    end
  end

  // wb keeps its last value when a grant is consumed without a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb        <= '0;
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      exc_src   <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      if (grant_any) begin
        if (sel_exc) begin
          exc_valid <= 1'b1;
          exc_src   <= grant_idx;
        end else if (sel_rd != 5'd0) begin
          wb.data  <= sel_data;
          wb.adr   <= sel_rd;
          wb_valid <= 1'b1;
        end
      end
    end
  end

  assign halted    = (state == ARB_HALT);
  assign state_dbg = state;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: priority, aging, rd=0, exception halt,
// flush and mid-stream reset.
module tb_wb_arbiter;
  import cpu_parameters::*;
  import interfaces_pkg::*;

  logic                         clk;
  logic                         rst_n;
  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC-1:0]           src_ready;
  logic [NUM_SRC-1:0][XLEN-1:0] src_data;
  logic [NUM_SRC-1:0][4:0]      src_rd;
  logic [NUM_SRC-1:0]           src_exc;
  logic                         flush;
  wb_bus                        wb;
  logic                         wb_valid;
  logic                         exc_valid;
  logic [1:0]                   exc_src;
  logic                         halted;
  arb_state_t                   state_dbg;

  int checks = 0;
  int errors = 0;

  wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_rd    (src_rd),
    .src_exc   (src_exc),
    .flush     (flush),
    .wb        (wb),
    .wb_valid  (wb_valid),
    .exc_valid (exc_valid),
    .exc_src   (exc_src),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic set_src(input int i, input logic v, input logic [XLEN-1:0] d,
                         input logic [4:0] rd, input logic e);
    src_valid[i] = v;
    src_data[i]  = d;
    src_rd[i]    = rd;
    src_exc[i]   = e;
  endtask

  task automatic idle_all();
    src_valid = '0;
    src_data  = '0;
    src_rd    = '0;
    src_exc   = '0;
    flush     = 1'b0;
  endtask

  function automatic logic [63:0] wbv(input logic [XLEN-1:0] d, input logic [4:0] rd);
    return 64'({d, rd});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [XLEN-1:0] MEM_D = 32'hAAAA_0001;
  localparam logic [XLEN-1:0] ALU_D = 32'hBBBB_0002;
  localparam logic [XLEN-1:0] CSR_D = 32'hCCCC_0003;

  logic [63:0] last_wb;

  initial begin
    rst_n = 1'b0;
    idle_all();
    src_valid = 3'b111;
    #12;
    check("reset_ready", 64'(src_ready), 64'd0);
    check("reset_wb", 64'(wb), 64'd0);
    check("reset_wb_valid", 64'(wb_valid), 64'd0);
    check("reset_exc_valid", 64'(exc_valid), 64'd0);
    check("reset_exc_src", 64'(exc_src), 64'd0);
    check("reset_halted", 64'(halted), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ARB_RUN));
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU alone, continuous
    set_src(SRC_ALU, 1'b1, 32'h1234, 5'd5, 1'b0);
    for (int c = 0; c < 3; c++) begin
      mid_cycle();
      check("alu_only_ready", 64'(src_ready), 64'b010);
      tick();
      check("alu_only_wb_valid", 64'(wb_valid), 64'd1);
      check("alu_only_wb", 64'(wb), wbv(32'h1234, 5'd5));
    end
    idle_all();
    tick();
    check("alu_stop_wb_valid", 64'(wb_valid), 64'd0);
    check("alu_stop_wb_hold", 64'(wb), wbv(32'h1234, 5'd5));

    // MEM and ALU contend: MEM x4, ALU on the 5th, repeat
    set_src(SRC_MEM, 1'b1, MEM_D, 5'd1, 1'b0);
    set_src(SRC_ALU, 1'b1, ALU_D, 5'd2, 1'b0);
    for (int c = 0; c < 10; c++) begin
      mid_cycle();
      check($sformatf("starve_ready_%0d", c), 64'(src_ready),
            (c % 5 == 4) ? 64'b010 : 64'b001);
      tick();
      check($sformatf("starve_wb_%0d", c), 64'(wb),
            (c % 5 == 4) ? wbv(ALU_D, 5'd2) : wbv(MEM_D, 5'd1));
      check($sformatf("starve_wbv_%0d", c), 64'(wb_valid), 64'd1);
    end
    idle_all();
    tick();

    // all three valid: MEM wins
    set_src(SRC_MEM, 1'b1, MEM_D, 5'd7, 1'b0);
    set_src(SRC_ALU, 1'b1, ALU_D, 5'd8, 1'b0);
    set_src(SRC_CSR, 1'b1, CSR_D, 5'd9, 1'b0);
    mid_cycle();
    check("all3_ready", 64'(src_ready), 64'b001);
    tick();
    check("all3_wb", 64'(wb), wbv(MEM_D, 5'd7));
    idle_all();

    // ALU rd=0: consumed, no write, wb held
    set_src(SRC_ALU, 1'b1, 32'h5555, 5'd0, 1'b0);
    mid_cycle();
    check("rd0_ready", 64'(src_ready), 64'b010);
    tick();
    check("rd0_wb_valid", 64'(wb_valid), 64'd0);
    check("rd0_wb_hold", 64'(wb), wbv(MEM_D, 5'd7));
    idle_all();

    // CSR exception -> halt
    set_src(SRC_CSR, 1'b1, CSR_D, 5'd3, 1'b1);
    mid_cycle();
    check("exc_ready", 64'(src_ready), 64'b100);
    tick();
    check("exc_valid", 64'(exc_valid), 64'd1);
    check("exc_src", 64'(exc_src), 64'd2);
    check("exc_wb_valid", 64'(wb_valid), 64'd0);
    check("exc_halted", 64'(halted), 64'd1);
    check("exc_wb_hold", 64'(wb), wbv(MEM_D, 5'd7));
    set_src(SRC_MEM, 1'b1, MEM_D, 5'd4, 1'b0);
    set_src(SRC_ALU, 1'b1, ALU_D, 5'd5, 1'b0);
    set_src(SRC_CSR, 1'b1, CSR_D, 5'd6, 1'b0);
    for (int c = 0; c < 10; c++) begin
      mid_cycle();
      check($sformatf("halt_ready_%0d", c), 64'(src_ready), 64'd0);
      tick();
      check($sformatf("halt_exc_pulse_%0d", c), 64'(exc_valid), 64'd0);
      check($sformatf("halt_wbv_%0d", c), 64'(wb_valid), 64'd0);
      check($sformatf("halt_halted_%0d", c), 64'(halted), 64'd1);
    end
    flush = 1'b1;
    mid_cycle();
    check("flush_ready", 64'(src_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_halted", 64'(halted), 64'd0);
    check("flush_wbv", 64'(wb_valid), 64'd0);
    mid_cycle();
    check("post_flush_ready", 64'(src_ready), 64'b001);
    tick();
    check("post_flush_wb", 64'(wb), wbv(MEM_D, 5'd4));
    check("post_flush_wbv", 64'(wb_valid), 64'd1);
    idle_all();

    // flush together with an exception grant: flush wins
    set_src(SRC_CSR, 1'b1, CSR_D, 5'd3, 1'b1);
    flush = 1'b1;
    mid_cycle();
    check("flush_exc_ready", 64'(src_ready), 64'd0);
    tick();
    check("flush_exc_valid", 64'(exc_valid), 64'd0);
    check("flush_exc_halted", 64'(halted), 64'd0);
    idle_all();
    tick();

    // build CSR age to the limit, then halt on a MEM exception
    set_src(SRC_MEM, 1'b1, MEM_D, 5'd10, 1'b0);
    set_src(SRC_CSR, 1'b1, CSR_D, 5'd11, 1'b0);
    for (int c = 0; c < 3; c++) begin
      mid_cycle();
      check($sformatf("age_build_ready_%0d", c), 64'(src_ready), 64'b001);
      tick();
    end
    src_exc[SRC_MEM] = 1'b1;
    mid_cycle();
    check("mem_exc_ready", 64'(src_ready), 64'b001);
    tick();
    check("mem_exc_src", 64'(exc_src), 64'd0);
    check("mem_exc_halted", 64'(halted), 64'd1);
    last_wb = 64'(wb);
    check("mem_exc_wb_hold", last_wb, wbv(MEM_D, 5'd10));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(src_ready), 64'd0);
    check("midrst_wb", 64'(wb), 64'd0);
    check("midrst_wbv", 64'(wb_valid), 64'd0);
    check("midrst_exc_valid", 64'(exc_valid), 64'd0);
    check("midrst_exc_src", 64'(exc_src), 64'd0);
    check("midrst_halted", 64'(halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    src_exc[SRC_MEM] = 1'b0;
    tick();
    mid_cycle();
    check("after_rst_priority", 64'(src_ready), 64'b001);
    tick();
    check("after_rst_wb", 64'(wb), wbv(MEM_D, 5'd10));
    idle_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Arbitrates the single register-file write port between the MEM, ALU and CSR result producers. Each producer presents results through a valid/ready handshake. The arbiter grants one source per cycle by fixed priority with an anti-starvation age override, and registers the granted result onto the write-back bus. A granted result that carries an exception is converted into an exception event instead of a register write, and the arbiter halts until the pipeline flushes. The block sits between the execute-stage producers and the register manager.

## Interface
- XLEN, 32, data width (from cpu_parameters)
- NUM_SRC, 3, number of requesters; index 0=MEM, 1=ALU, 2=CSR
- STARVE_LIMIT, 4, consecutive lost cycles before a waiting source is forced to win
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- src_valid  in  NUM_SRC  result offered by source i
- src_ready  out  NUM_SRC  source i granted this cycle (one-hot or zero)
- src_data  in  NUM_SRC x XLEN  result value per source
- src_rd  in  NUM_SRC x 5  destination register per source
- src_exc  in  NUM_SRC  result carries an exception
- flush  in  1  pipeline flush; clears halt and pending output
- wb  out  wb_bus  registered write-back {data, adr}
- wb_valid  out  1  wb is a real register write this cycle
- exc_valid  out  1  one-cycle exception event
- exc_src  out  2  index of the source that raised the exception
- halted  out  1  arbiter is in HALT

## Operation
- States: RUN and HALT. Reset enters RUN.
- RUN, grant selection:
  - Candidates are sources with src_valid=1.
  - If any candidate has age >= STARVE_LIMIT, the lowest-index such candidate wins.
  - Otherwise the lowest-index candidate wins.
  - src_ready for the winner only. Transfer happens when valid & ready.
- Age counters, one per source, saturating at STARVE_LIMIT:
  - Increment when the source is valid but not granted.
  - Clear when the source is granted, or when it is not valid.
- Granted result, no exception, src_rd != 0: wb <= {src_data, src_rd}, wb_valid <= 1.
- Granted result, no exception, src_rd == 0: consumed, wb_valid <= 0, wb holds its previous value.
- Granted result, src_exc=1:
  - No write; wb_valid <= 0.
  - exc_valid <= 1 and exc_src <= index.
  - Next state is HALT.
- HALT:
  - All src_ready=0 and all age counters frozen.
  - halted=1 and wb_valid=0.
  - Remains in HALT until flush.
- flush, in either state:
  - Next state RUN; ages cleared; wb_valid <= 0, exc_valid <= 0.
  - No grant in the flush cycle (src_ready=0).
- The register manager never back-pressures; wb_valid is always accepted.

## Timing
- src_ready is combinational from src_valid, age, state and flush. No combinational path from src_data or src_rd.
- Latency: result accepted at the edge ending cycle N is visible on wb/wb_valid in cycle N+1, for exactly one cycle unless another grant follows.
- Throughput: one write per cycle. Back-to-back grants give back-to-back wb_valid.
- exc_valid is a one-cycle pulse in cycle N+1. halted rises in cycle N+1.
- Simultaneous flush and exception grant: flush wins; no grant, no exc_valid.
- Reset mid-operation: all state is cleared asynchronously.
- Reset values:
  - wb = '0, wb_valid = 0
  - exc_valid = 0, exc_src = 0
  - halted = 0
  - src_ready = 0 while rst_n is low
  - all ages = 0, state = RUN
- Age width is $clog2(STARVE_LIMIT+1).

## Structure
- wb_bus stays in interfaces_pkg.
- Source-index constants (SRC_MEM=0, SRC_ALU=1, SRC_CSR=2) and the arbiter state enum go in cpu_parameters.
- Sub-module wb_age_counter, instantiated NUM_SRC times: saturating counter with inc, clr and freeze inputs and a starved output.

## Test plan
- ALU only valid, rd=5, data=0x1234 every cycle: wb_valid every cycle from cycle 1; wb={0x1234,5}; ALU ready every cycle.
- MEM and ALU both valid continuously, STARVE_LIMIT=4: MEM wins 4 cycles, ALU wins the 5th, then the pattern repeats. No source waits more than 4 cycles.
- MEM, ALU and CSR all valid in one cycle: MEM granted; next cycle wb={mem_data,mem_rd}; ALU and CSR ages become 1.
- CSR granted with src_exc=1:
  - Next cycle exc_valid=1, exc_src=2, wb_valid=0, halted=1.
  - src_ready stays 0 for 10 cycles of valid input.
  - flush returns to RUN; the first grant occurs the cycle after flush.
- ALU grant with rd=0: src_ready=1, wb_valid stays 0, wb unchanged.
- Assert rst_n=0 mid-stream while halted with ages non-zero: all outputs are immediately at reset values; after release, the first grant is by pure priority.
